// File: rtl/edge_frame_capture.sv
// edge_frame_capture: captures the raster-ordered Sobel byte stream into a 4-bit frame buffer.
// Once a full frame is held, it replays the buffer forever as a pull-driven pixel stream.
module edge_frame_capture #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [15:0] H,
    input  logic [15:0] W,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    input  logic        rd_req,
    output logic [3:0]  stream_out,
    output logic        stream_valid,
    output logic        frame_ready,
    output logic        overflow
);

    localparam int unsigned Depth   = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned AddrW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [15:0] ColLast = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] RowLast = 16'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StReady
    } state_e;

    state_e      state_q;
    logic [15:0] h_q, w_q;
    logic [15:0] wrow_q, wcol_q;
    logic [15:0] rrow_q, rcol_q;
    logic [31:0] cnt_q;
    logic        frame_ready_q, overflow_q;

    // Read pipeline: stage 1 is the RAM read, stage 2 the registered output.
    logic        rd_vld_q, rd_in_q;
    logic [3:0]  mem_rd_q;
    logic [3:0]  stream_out_q;
    logic        stream_valid_q;

    logic [3:0]  mem [Depth];

    logic [31:0]      total_c;
    logic [31:0]      cnt_inc_c;
    logic             wr_accept_c, wr_in_range_c, wr_en_c;
    logic             rd_accept_c, rd_in_range_c;
    logic [31:0]      waddr_full_c, raddr_full_c;
    logic [AddrW-1:0] waddr_c, raddr_c;

    // Only the upper nibble is kept; the lower bits are intentionally dropped.
    logic unused_pix_lsb;
    assign unused_pix_lsb = ^pix_in[3:0];

    assign total_c   = 32'(h_q) * 32'(w_q);
    assign cnt_inc_c = cnt_q + 32'd1;

    // start wins over a coincident strobe, so that byte is never written.
    assign wr_accept_c   = (state_q == StCapture) && pix_valid && !start;
    assign wr_in_range_c = (32'(wcol_q) < IMG_WIDTH) && (32'(wrow_q) < IMG_HEIGHT);
    assign wr_en_c       = wr_accept_c && wr_in_range_c;
    assign waddr_full_c  = 32'(wrow_q) * IMG_WIDTH + 32'(wcol_q);
    assign waddr_c       = waddr_full_c[AddrW-1:0];

    // Read counters always stay inside the buffer; the H/W compare masks stale locations.
    assign rd_accept_c   = (state_q == StReady) && rd_req && !start;
    assign rd_in_range_c = (rrow_q < h_q) && (rcol_q < w_q);
    assign raddr_full_c  = 32'(rrow_q) * IMG_WIDTH + 32'(rcol_q);
    assign raddr_c       = raddr_full_c[AddrW-1:0];

    // Frame buffer: single write port, registered read port, no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[waddr_c] <= pix_in[7:4];
        end
        if (rd_accept_c) begin
            mem_rd_q <= mem[raddr_c];
        end
    end

    // Control FSM: capture/replay counters and the sticky status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            h_q           <= 16'd0;
            w_q           <= 16'd0;
            wrow_q        <= 16'd0;
            wcol_q        <= 16'd0;
            rrow_q        <= 16'd0;
            rcol_q        <= 16'd0;
            cnt_q         <= 32'd0;
            frame_ready_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else if (start) begin
            h_q        <= H;
            w_q        <= W;
            wrow_q     <= 16'd0;
            wcol_q     <= 16'd0;
            rrow_q     <= 16'd0;
            rcol_q     <= 16'd0;
            cnt_q      <= 32'd0;
            overflow_q <= 1'b0;
            // An empty source image is complete immediately and displays as all zero.
            if ((H == 16'd0) || (W == 16'd0)) begin
                state_q       <= StReady;
                frame_ready_q <= 1'b1;
            end else begin
                state_q       <= StCapture;
                frame_ready_q <= 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StCapture: begin
                    if (pix_valid) begin
                        cnt_q <= cnt_inc_c;
                        if (wcol_q == w_q - 16'd1) begin
                            wcol_q <= 16'd0;
                            wrow_q <= wrow_q + 16'd1;
                        end else begin
                            wcol_q <= wcol_q + 16'd1;
                        end
                        if (cnt_inc_c == total_c) begin
                            state_q       <= StReady;
                            frame_ready_q <= 1'b1;
                        end
                    end
                end
                StReady: begin
                    if (pix_valid) begin
                        overflow_q <= 1'b1;
                    end
                    if (rd_req) begin
                        if (rcol_q == ColLast) begin
                            rcol_q <= 16'd0;
                            rrow_q <= (rrow_q == RowLast) ? 16'd0 : rrow_q + 16'd1;
                        end else begin
                            rcol_q <= rcol_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output stage: an in-flight read always completes, even across a new start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_vld_q       <= 1'b0;
            rd_in_q        <= 1'b0;
            stream_valid_q <= 1'b0;
            stream_out_q   <= 4'd0;
        end else begin
            rd_vld_q       <= rd_accept_c;
            rd_in_q        <= rd_in_range_c;
            stream_valid_q <= rd_vld_q;
            stream_out_q   <= (rd_vld_q && rd_in_q) ? mem_rd_q : 4'd0;
        end
    end

    assign stream_out   = stream_out_q;
    assign stream_valid = stream_valid_q;
    assign frame_ready  = frame_ready_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_edge_frame_capture.sv
// Bench for edge_frame_capture on an 8x8 buffer: table of capture/replay scenarios plus
// hand-written sequences for overflow, restart, coincident start and asynchronous reset.
module tb_edge_frame_capture;

    localparam int IW = 8;
    localparam int IH = 8;

    typedef struct {
        logic [15:0] h;
        logic [15:0] w;
        int          n_pix;
        int          mode;
        int          n_rd;
        logic        exp_ready_at_start;
        logic        exp_overflow;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] H = 16'd0;
    logic [15:0] W = 16'd0;
    logic [7:0]  pix_in = 8'd0;
    logic        pix_valid = 1'b0;
    logic        rd_req = 1'b0;
    logic [3:0]  stream_out;
    logic        stream_valid;
    logic        frame_ready;
    logic        overflow;

    int         checks = 0;
    int         errors = 0;
    int         sv_seen = 0;
    int         base;
    logic [3:0] exp_q[$];
    vec_t       vecs[5];

    edge_frame_capture #(
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .H           (H),
        .W           (W),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .rd_req      (rd_req),
        .stream_out  (stream_out),
        .stream_valid(stream_valid),
        .frame_ready (frame_ready),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mode 0: byte k is 0x10*k; mode 1: all 0xFF.
    function automatic logic [7:0] pix_of(input int mode, input int k);
        if (mode == 1) return 8'hFF;
        return 8'((k * 16) & 255);
    endfunction

    // Expected value of the i-th replayed pixel after a fresh start.
    function automatic logic [3:0] exp_at(input int i, input int h, input int w, input int mode);
        int r;
        int c;
        logic [7:0] p;
        r = (i / IW) % IH;
        c = i % IW;
        if (r < h && c < w) begin
            p = pix_of(mode, r * w + c);
            return p[7:4];
        end
        return 4'd0;
    endfunction

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (rstn && stream_valid) begin
            sv_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_stream_valid: got 1 expected 0 at %0t", $time);
            end else begin
                chk("stream_out", 32'(stream_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_start(input logic [15:0] h, input logic [15:0] w, input bit with_pix);
        start = 1'b1;
        H = h;
        W = w;
        if (with_pix) begin
            pix_valid = 1'b1;
            pix_in = 8'hE0;
        end
        @(negedge clk);
        start = 1'b0;
        pix_valid = 1'b0;
        pix_in = 8'd0;
    endtask

    task automatic feed(input int n, input int mode, input int total);
        for (int k = 0; k < n; k++) begin
            pix_valid = 1'b1;
            pix_in = pix_of(mode, k);
            @(negedge clk);
            chk("frame_ready_on_strobe", 32'(frame_ready), (k == total - 1) ? 32'd1 : 32'd0);
        end
        pix_valid = 1'b0;
        pix_in = 8'd0;
    endtask

    task automatic read_frame(input int n, input int h, input int w, input int mode);
        for (int i = 0; i < n; i++) begin
            rd_req = 1'b1;
            exp_q.push_back(exp_at(i, h, w, mode));
            @(negedge clk);
        end
        rd_req = 1'b0;
        for (int t = 0; t < 8 && exp_q.size() != 0; t++) @(negedge clk);
        chk("replay_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stream_out"}, 32'(stream_out), 32'd0);
        chk({tag, "_stream_valid"}, 32'(stream_valid), 32'd0);
        chk({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'd4,  16'd4,  16,  0, 65, 1'b0, 1'b0};
        vecs[1] = '{16'd10, 16'd10, 100, 1, 64, 1'b0, 1'b0};
        vecs[2] = '{16'd0,  16'd5,  0,   0, 64, 1'b1, 1'b0};
        vecs[3] = '{16'd2,  16'd3,  6,   0, 70, 1'b0, 1'b0};
        vecs[4] = '{16'd2,  16'd2,  4,   0, 8,  1'b0, 1'b0};

        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            do_start(vecs[v].h, vecs[v].w, 1'b0);
            chk("ready_after_start", 32'(frame_ready), 32'(vecs[v].exp_ready_at_start));
            feed(vecs[v].n_pix, vecs[v].mode, vecs[v].n_pix);
            read_frame(vecs[v].n_rd, int'(vecs[v].h), int'(vecs[v].w), vecs[v].mode);
            chk("overflow_after_replay", 32'(overflow), 32'(vecs[v].exp_overflow));
        end

        // Strobe after completion sets sticky overflow; restart clears both flags.
        pix_valid = 1'b1;
        pix_in = 8'h55;
        @(negedge clk);
        pix_valid = 1'b0;
        chk("overflow_set", 32'(overflow), 32'd1);
        chk("ready_kept", 32'(frame_ready), 32'd1);
        do_start(16'd4, 16'd4, 1'b0);
        chk("overflow_cleared", 32'(overflow), 32'd0);
        chk("ready_cleared", 32'(frame_ready), 32'd0);
        base = sv_seen;
        rd_req = 1'b1;
        repeat (3) @(negedge clk);
        rd_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_read_in_capture", 32'(sv_seen - base), 32'd0);

        // Coincident start and strobe: the byte is dropped, next strobe lands at (0,0).
        do_start(16'd4, 16'd4, 1'b1);
        feed(16, 0, 16);
        read_frame(16, 4, 4, 0);

        // Asynchronous reset mid-replay with a read in flight.
        chk("ready_before_reset", 32'(frame_ready), 32'd1);
        rd_req = 1'b1;
        @(negedge clk);
        #2;
        rstn = 1'b0;
        rd_req = 1'b0;
        #1;
        chk_all_zero("replay_reset");
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;

        // Asynchronous reset after 5 of 16 strobes.
        do_start(16'd4, 16'd4, 1'b0);
        feed(5, 0, 16);
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("capture_reset");
        @(negedge clk);
        rstn = 1'b1;
        base = sv_seen;
        rd_req = 1'b1;
        repeat (10) @(negedge clk);
        rd_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_read_after_reset", 32'(sv_seen - base), 32'd0);
        chk("ready_after_reset", 32'(frame_ready), 32'd0);

        // Recovery: a fresh complete capture replays correctly.
        do_start(16'd4, 16'd4, 1'b0);
        feed(16, 0, 16);
        read_frame(20, 4, 4, 0);
        chk("overflow_final", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_frame_capture.md
# edge_frame_capture

Downstream neighbour of the Sobel stage. Captures the raster-ordered 8-bit Sobel magnitude bytes (the same strobe/byte pair that feeds the UART transmitter), quantises each byte to 4 bits and stores it in a frame buffer of IMG_WIDTH x IMG_HEIGHT. Once a full frame is held, it replays the buffer indefinitely as a pull-driven 4-bit pixel stream for the VGA output stage.

## Interface
- IMG_WIDTH, 640, buffer/display width in pixels
- IMG_HEIGHT, 480, buffer/display height in pixels
- clk  input  1  system clock, all logic on rising edge
- rstn  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; latches H/W and begins a new capture (driven by the RAM all-loaded flag)
- H  input  16  source image height from the parser
- W  input  16  source image width from the parser
- pix_in  input  8  Sobel output byte
- pix_valid  input  1  one-cycle strobe, pix_in valid
- rd_req  input  1  consumer pixel request (one per VGA pixel tick)
- stream_out  output  4  replayed pixel
- stream_valid  output  1  stream_out valid, one-cycle pulse
- frame_ready  output  1  full frame captured; replay permitted
- overflow  output  1  sticky; pix_valid arrived after the frame was complete

## Operation
- States: IDLE, CAPTURE, READY.
- IDLE: wait for start. pix_valid and rd_req are ignored.
- start (any state): latch H_l=H, W_l=W; zero the write row/column, the pixel counter and the read row/column; clear frame_ready and overflow.
  - If H==0 or W==0: go to READY, and the whole displayed frame is 0.
  - Otherwise: go to CAPTURE.
- CAPTURE, on pix_valid:
  - If wcol<IMG_WIDTH and wrow<IMG_HEIGHT: write pix_in[7:4] to mem[wrow*IMG_WIDTH+wcol]. Otherwise discard (crop).
  - wcol increments and wraps to 0 at W_l-1, then wrow increments.
  - The 32-bit counter counts accepted strobes. When it reaches H_l*W_l (32-bit product), go to READY and set frame_ready.
- READY: pix_valid sets overflow and is otherwise ignored.
  - On rd_req, read at (rrow, rcol). The output is the memory value if rrow<H_l and rcol<W_l, else 0.
  - rcol wraps at IMG_WIDTH-1 and increments rrow. rrow wraps at IMG_HEIGHT-1 to 0, so the frame repeats indefinitely.
- rd_req outside READY: ignored, no stream_valid, read counters unchanged.
- Memory is single-write/single-read synchronous, inferable as BRAM. It is not cleared on reset. Never-written locations are masked by the H_l/W_l compare.
- start in the same cycle as pix_valid: start wins and the pixel is dropped.
- Counters and address arithmetic are unsigned.
  - Write address width: clog2(IMG_WIDTH*IMG_HEIGHT).
  - Row/column counters: 16 bits.

## Timing
- Reset values: stream_out=0, stream_valid=0, frame_ready=0, overflow=0, state=IDLE, all counters 0.
- start to state change: 1 cycle (state updated at the edge sampling start).
- Write: a pixel strobed in cycle N is readable from cycle N+1.
- frame_ready rises at the edge that samples the final accepted pix_valid.
- Read latency: rd_req sampled at edge N gives stream_out/stream_valid valid for the cycle after edge N+1. stream_valid is high for exactly one cycle per accepted rd_req.
- Back-to-back rd_req on every cycle is supported at full throughput.
- A start during READY drops frame_ready at the next edge. A read already in flight still completes with its stream_valid, but frame_ready is 0 during that cycle.
- Reset asserted mid-capture or mid-replay: immediate return to the reset values. The buffer contents are undefined thereafter.

## Test plan
- Reset, then H=4, W=4 (IMG 8x8): start, 16 strobes with pix_in=0x10*k. frame_ready rises on the 16th. Replay of 64 rd_req gives row 0 = 0,1,2,3,0,0,0,0; rows 4-7 all 0; the 65th request returns pixel (0,0)=0.
- Crop with H=10, W=10 (IMG 8x8): 100 strobes, all 0xFF. frame_ready only after the 100th. Every replayed pixel is 0xF and no overflow.
- H=0: start gives frame_ready the next cycle. All replayed pixels are 0.
- Overflow and restart: complete a 2x2 frame, then pulse pix_valid, giving overflow=1. Then start gives overflow=0 and frame_ready=0. rd_req in CAPTURE gives no stream_valid.
- start coincident with pix_valid: that byte is not stored. The next strobe lands at (0,0).
- rstn asserted mid-CAPTURE after 5 of 16 pixels: all outputs 0 asynchronously. After release, rd_req gives no stream_valid until a new start and a complete capture.
